exec_writeback: RTL

EXEC_WRITEBACK -- requirements
Module: exec_writeback

---
 rtl/exec_writeback_pkg.sv | 36 +++
 rtl/exec_writeback_mul16_seq.sv | 65 ++++++
 rtl/exec_writeback.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/exec_writeback_pkg.sv
// exec_writeback_pkg
//   Shared encodings for the fetch and execute stages: opcodes, destination
//   modes, the writeback FSM states, and an opcode legality helper.
package exec_writeback_pkg;

    // Opcode map. B..F are reserved/illegal.
    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    // Destination modes.
    localparam logic [1:0] DM_REG     = 2'b00;
    localparam logic [1:0] DM_MEM_DIR = 2'b01;
    localparam logic [1:0] DM_MEM_IDX = 2'b10;
    localparam logic [1:0] DM_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/exec_writeback_mul16_seq.sv
// mul16_seq
//   16x16 iterative shift-add multiplier, one multiplier bit per cycle.
//   Ports:
//     clk, clr      clock, async active-high reset
//     load          capture a/b and start a 16-cycle run
//     a, b          multiplicand / multiplier
//     done          one-cycle pulse the cycle after the 16th iteration
//     product       full 32-bit product, valid when done is high
module mul16_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [31:0] product
);

    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {16'h0000, a};
            mplier_d = b;
            cnt_d    = 5'd16;
        end else if (cnt_q != 5'd0) begin
            if (mplier_q[0])
                acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 5'd1;
            done_d   = (cnt_q == 5'd1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/exec_writeback.sv
// exec_writeback
//   Execute + writeback stage. Captures opcode/operands on start in IDLE,
//   computes in EXEC (1 cycle) or MUL (16 iterations + 1), then spends one
//   cycle in WB where done/err and the write enables pulse.
//   Ports:
//     clk, clr                      clock, async active-high reset
//     start, opcode, a, b           operation request (sampled in IDLE only)
//     dest_mode, dest_reg, dest_addr destination selection
//     busy, done, err               status
//     result, flag_z/n/c/v          registered result and flags
//     reg_we/reg_index/reg_wdata    register-file write port
//     mem_we/mem_addr/mem_wdata     memory write port
module exec_writeback
    import exec_writeback_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    dest_mode,
    input  logic [3:0]    dest_reg,
    input  logic [AW-1:0] dest_addr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] result,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_c,
    output logic          flag_v,
    output logic          reg_we,
    output logic [3:0]    reg_index,
    output logic [DW-1:0] reg_wdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata
);

    state_e        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]    dm_q, dm_d;
    logic [3:0]    dreg_q, dreg_d;
    logic [AW-1:0] daddr_q, daddr_d;
    logic [DW-1:0] result_q, result_d;
    logic          z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic [3:0]    reg_index_q, reg_index_d;
    logic [DW-1:0] reg_wdata_q, reg_wdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          mul_load, mul_done;
    logic [31:0]   mul_prod;

    logic [DW:0]   sum_w, diff_w;
    logic [DW-1:0] alu_res;
    logic          alu_c, alu_v;

    mul16_seq u_mul (
        .clk     (clk),
        .clr     (clr),
        .load    (mul_load),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle ALU on the captured operands. CMP produces the a-b
    // difference here so Z/N can be derived; the result register is not
    // written for CMP.
    always_comb begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        diff_w  = {1'b0, a_q} - {1'b0, b_q};
        alu_res = a_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OP_MOV: alu_res = a_q;
            OP_ADD: begin
                alu_res = sum_w[DW-1:0];
                alu_c   = sum_w[DW];
                alu_v   = (a_q[DW-1] == b_q[DW-1]) && (sum_w[DW-1] != a_q[DW-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff_w[DW-1:0];
                alu_c   = diff_w[DW];  // borrow, i.e. a < b unsigned
                alu_v   = (a_q[DW-1] != b_q[DW-1]) && (diff_w[DW-1] != a_q[DW-1]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_NOT: alu_res = ~a_q;
            OP_SHL: alu_res = a_q << b_q[3:0];
            OP_SHR: alu_res = a_q >> b_q[3:0];
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        dm_d        = dm_q;
        dreg_d      = dreg_q;
        daddr_d     = daddr_q;
        result_d    = result_q;
        z_d         = z_q;
        n_d         = n_q;
        c_d         = c_q;
        v_d         = v_q;
        reg_index_d = reg_index_q;
        reg_wdata_d = reg_wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mul_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = opcode;
                    a_d      = a;
                    b_d      = b;
                    dm_d     = dest_mode;
                    dreg_d   = dest_reg;
                    daddr_d  = dest_addr;
                    mul_load = (opcode == OP_MUL);
                    state_d  = (opcode == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
                // Illegal opcodes leave result and flags untouched.
                if (op_legal(op_q)) begin
                    if (op_q != OP_CMP)
                        result_d = alu_res;
                    z_d = (alu_res == '0);
                    n_d = alu_res[DW-1];
                    c_d = alu_c;
                    v_d = alu_v;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d  = ST_WB;
                    result_d = mul_prod[DW-1:0];
                    z_d      = (mul_prod[DW-1:0] == '0);
                    n_d      = mul_prod[DW-1];
                    c_d      = |mul_prod[31:16];
                    v_d      = 1'b0;
                end
            end
            default: state_d = ST_IDLE;  // ST_WB
        endcase

        // Write-port payload is latched on entry to WB so it is stable for
        // the whole WB cycle; the enables themselves decode from the state.
        if (state_d == ST_WB && state_q != ST_WB) begin
            reg_index_d = dreg_q;
            reg_wdata_d = result_d;
            mem_addr_d  = daddr_q;
            mem_wdata_d = result_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            dm_q        <= '0;
            dreg_q      <= '0;
            daddr_q     <= '0;
            result_q    <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            reg_index_q <= '0;
            reg_wdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dm_q        <= dm_d;
            dreg_q      <= dreg_d;
            daddr_q     <= daddr_d;
            result_q    <= result_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            reg_index_q <= reg_index_d;
            reg_wdata_q <= reg_wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Enables decode straight from the state register so an async clr
    // removes them in the same instant it forces IDLE.
    logic in_wb, bad_op, no_write;
    assign in_wb    = (state_q == ST_WB);
    assign bad_op   = !op_legal(op_q) || (dm_q == DM_ILLEGAL);
    assign no_write = bad_op || (op_q == OP_CMP);

    assign busy      = (state_q != ST_IDLE);
    assign done      = in_wb;
    assign err       = in_wb && bad_op;
    assign reg_we    = in_wb && !no_write && (dm_q == DM_REG);
    assign mem_we    = in_wb && !no_write && (dm_q == DM_MEM_DIR || dm_q == DM_MEM_IDX);
    assign result    = result_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign reg_index = reg_index_q;
    assign reg_wdata = reg_wdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
